spi_slave: RTL and testbench

- SPI slave endpoint for a single-master, single-slave link.
- Exchanges one DATA_WIDTH-bit word per chip-select (CS) frame, full duplex, LSB first.
- Shifts data out on MISO on SCLK rising edges and samples MOSI on SCLK falling edges (master drives MOSI on rising edges and samples MISO on falling edges).
- Parallel side connects to local logic: a word to send and the last word received.

---
 rtl/spi_pkg.sv | 14 +
 rtl/spi_shift_reg.sv | 43 ++++
 rtl/spi_slave.sv | 87 ++++++++
 tb/tb_spi_slave.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared constants for the SPI slave endpoint: default word length, bit order, counter sizing.
package spi_pkg;

    localparam int unsigned SPI_DATA_WIDTH = 8;
    localparam int unsigned LSB_FIRST      = 1;

    // Bit-counter width for a w-bit word; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    localparam int unsigned SPI_CNT_W = cnt_width(SPI_DATA_WIDTH);

endpackage

// File: rtl/spi_shift_reg.sv
// LSB-first shift register with parallel load, shift enable and a modulo-W bit counter.
module spi_shift_reg
    import spi_pkg::*;
#(
    parameter int unsigned W     = SPI_DATA_WIDTH,
    parameter int unsigned CNT_W = cnt_width(W)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [W-1:0]     i_load_data,
    input  logic             i_shift_en,
    input  logic             i_count_en,
    input  logic             i_serial_in,
    output logic [W-1:0]     o_data,
    output logic [CNT_W-1:0] o_count
);

    logic [W-1:0]     r_data;
    logic [CNT_W-1:0] r_count;

    // Load takes priority and restarts the counter; otherwise shift toward bit 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data  <= '0;
            r_count <= '0;
        end else if (i_load) begin
            r_data  <= i_load_data;
            r_count <= '0;
        end else begin
            if (i_shift_en) begin
                r_data <= {i_serial_in, r_data[W-1:1]};
            end
            if (i_count_en) begin
                r_count <= (r_count == CNT_W'(W-1)) ? '0 : r_count + CNT_W'(1);
            end
        end
    end

    assign o_data  = r_data;
    assign o_count = r_count;

endmodule

// File: rtl/spi_slave.sv
// SPI slave: one full-duplex LSB-first word per CS frame; MISO launched on SCLK rise, MOSI sampled on fall.
// Optional SPI_SLAVE_MISO_TRISTATE_EN: MISO floats whenever CS is high or reset is asserted.
module spi_slave
    import spi_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = SPI_DATA_WIDTH
) (
    input  logic                  SCLK,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] slaveDataToSend,
    output logic [DATA_WIDTH-1:0] slaveDataReceived,
    input  logic                  CS,
    input  logic                  MOSI,
    output logic                  MISO
);

    localparam int unsigned CNT_W = cnt_width(DATA_WIDTH);

    logic                  w_sclk_n;
    logic                  w_active;
    logic [DATA_WIDTH-1:0] w_tx_data;
    logic [DATA_WIDTH-1:0] w_rx_data;
    logic [CNT_W-1:0]      w_tx_cnt;
    logic [CNT_W-1:0]      w_rx_cnt;
    logic                  r_miso;
    logic [DATA_WIDTH-1:0] r_rx_word;

    assign w_sclk_n = ~SCLK;
    assign w_active = ~CS;

    // Transmit word is captured while idle and held stable for the frame; the counter selects the bit.
    spi_shift_reg #(
        .W     (DATA_WIDTH),
        .CNT_W (CNT_W)
    ) u_tx (
        .clk         (SCLK),
        .rst_n       (reset),
        .i_load      (CS),
        .i_load_data (slaveDataToSend),
        .i_shift_en  (1'b0),
        .i_count_en  (w_active),
        .i_serial_in (1'b0),
        .o_data      (w_tx_data),
        .o_count     (w_tx_cnt)
    );

    spi_shift_reg #(
        .W     (DATA_WIDTH),
        .CNT_W (CNT_W)
    ) u_rx (
        .clk         (w_sclk_n),
        .rst_n       (reset),
        .i_load      (CS),
        .i_load_data ('0),
        .i_shift_en  (w_active),
        .i_count_en  (w_active),
        .i_serial_in (MOSI),
        .o_data      (w_rx_data),
        .o_count     (w_rx_cnt)
    );

    always_ff @(posedge SCLK or negedge reset) begin
        if (!reset) begin
            r_miso <= 1'b0;
        end else if (w_active) begin
            r_miso <= w_tx_data[w_tx_cnt];
        end
    end

    // Publish only on the last bit of a word so aborted frames leave the old word in place.
    always_ff @(posedge w_sclk_n or negedge reset) begin
        if (!reset) begin
            r_rx_word <= '0;
        end else if (w_active && (w_rx_cnt == CNT_W'(DATA_WIDTH-1))) begin
            r_rx_word <= {MOSI, w_rx_data[DATA_WIDTH-1:1]};
        end
    end

    assign slaveDataReceived = r_rx_word;

`ifdef SPI_SLAVE_MISO_TRISTATE_EN
    assign MISO = (CS || !reset) ? 1'bz : r_miso;
`else
    assign MISO = r_miso;
`endif

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave acting as SPI master: frames, back-to-back, abort, mid-frame changes, wrap.
module tb_spi_slave;

    logic       SCLK;
    logic       reset;
    logic [7:0] slaveDataToSend;
    logic [7:0] slaveDataReceived;
    logic       CS;
    logic       MOSI;
    wire        MISO;

    int n_checks;
    int n_pass;

`ifdef SPI_SLAVE_MISO_TRISTATE_EN
    localparam logic EXP_RESET_MISO = 1'bz;
    localparam logic EXP_IDLE_Z     = 1'b1;
`else
    localparam logic EXP_RESET_MISO = 1'b0;
    localparam logic EXP_IDLE_Z     = 1'b0;
`endif

    spi_slave #(.DATA_WIDTH(8)) dut (
        .SCLK              (SCLK),
        .reset             (reset),
        .slaveDataToSend   (slaveDataToSend),
        .slaveDataReceived (slaveDataReceived),
        .CS                (CS),
        .MOSI              (MOSI),
        .MISO              (MISO)
    );

    initial SCLK = 1'b0;
    always #5 SCLK = ~SCLK;

    // Master side of one frame: drives MOSI after each rise, samples MISO after each fall, then raises CS.
    task automatic run_frame(input logic [7:0] tx, input logic [15:0] rx, input int nbits,
                             input int chg_at, input logic [7:0] chg_val, output logic [15:0] got);
        got = '0;
        slaveDataToSend = tx;
        @(posedge SCLK);
        @(negedge SCLK);
        #1 CS = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            @(posedge SCLK);
            #1 MOSI = rx[i];
            if (i == chg_at) slaveDataToSend = chg_val;
            @(negedge SCLK);
            #1 got[i] = MISO;
        end
        CS = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        CS = 1'($urandom);
        MOSI = 1'($urandom);
        slaveDataToSend = 8'($urandom);
        repeat (3) @(posedge SCLK);
        @(negedge SCLK);
        #1;
        n_checks++;
        if (slaveDataReceived !== 8'h00) $display("FAIL reset_rx: got %h want 00", slaveDataReceived);
        else n_pass++;
        n_checks++;
        if (MISO !== EXP_RESET_MISO) $display("FAIL reset_miso: got %b want %b", MISO, EXP_RESET_MISO);
        else n_pass++;
        CS = 1'b1;
        reset = 1'b1;
        repeat (2) @(posedge SCLK);
        #1;
        n_checks++;
        if (slaveDataReceived !== 8'h00) $display("FAIL post_reset_rx: got %h want 00", slaveDataReceived);
        else n_pass++;
        n_checks++;
        if (MISO !== EXP_RESET_MISO) $display("FAIL post_reset_miso: got %b want %b", MISO, EXP_RESET_MISO);
        else n_pass++;
    endtask

    task automatic test_full_duplex();
        logic [15:0] got;
        run_frame(8'h09, 16'h0053, 8, -1, 8'h00, got);
        n_checks++;
        if (slaveDataReceived !== 8'h53) $display("FAIL fd_rx: got %h want 53", slaveDataReceived);
        else n_pass++;
        n_checks++;
        if (got[7:0] !== 8'h09) $display("FAIL fd_tx: got %h want 09", got[7:0]);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [7:0]  tx_v [3] = '{8'h98, 8'hFF, 8'h98};
        logic [7:0]  rx_v [3] = '{8'h3C, 8'h55, 8'h5F};
        logic [15:0] got;
        for (int k = 0; k < 3; k++) begin
            run_frame(tx_v[k], {8'h00, rx_v[k]}, 8, -1, 8'h00, got);
            n_checks++;
            if (slaveDataReceived !== rx_v[k])
                $display("FAIL b2b_rx[%0d]: got %h want %h", k, slaveDataReceived, rx_v[k]);
            else n_pass++;
            n_checks++;
            if (got[7:0] !== tx_v[k]) $display("FAIL b2b_tx[%0d]: got %h want %h", k, got[7:0], tx_v[k]);
            else n_pass++;
        end
    endtask

    // Last frame sent 0x98, so an always-driven MISO rests at bit 7 = 1.
    task automatic test_miso_idle();
        logic exp;
        exp = EXP_IDLE_Z ? 1'bz : 1'b1;
        repeat (3) @(posedge SCLK);
        #1;
        n_checks++;
        if (MISO !== exp) $display("FAIL idle_miso: got %b want %b", MISO, exp);
        else n_pass++;
    endtask

    task automatic test_abort();
        logic [15:0] got;
        run_frame(8'h11, 16'h00A5, 4, -1, 8'h00, got);
        repeat (2) @(posedge SCLK);
        #1;
        n_checks++;
        if (slaveDataReceived !== 8'h5F) $display("FAIL abort_hold: got %h want 5F", slaveDataReceived);
        else n_pass++;
        run_frame(8'hC3, 16'h003C, 8, -1, 8'h00, got);
        n_checks++;
        if (slaveDataReceived !== 8'h3C) $display("FAIL abort_next_rx: got %h want 3C", slaveDataReceived);
        else n_pass++;
        n_checks++;
        if (got[7:0] !== 8'hC3) $display("FAIL abort_next_tx: got %h want C3", got[7:0]);
        else n_pass++;
    endtask

    task automatic test_midframe_tx_change();
        logic [15:0] got;
        run_frame(8'hA6, 16'h0071, 8, 3, 8'h00, got);
        n_checks++;
        if (got[7:0] !== 8'hA6) $display("FAIL mid_tx_change: got %h want A6", got[7:0]);
        else n_pass++;
        n_checks++;
        if (slaveDataReceived !== 8'h71) $display("FAIL mid_tx_change_rx: got %h want 71", slaveDataReceived);
        else n_pass++;
    endtask

    task automatic test_midframe_reset();
        logic [15:0] got;
        slaveDataToSend = 8'hFF;
        @(posedge SCLK);
        @(negedge SCLK);
        #1 CS = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge SCLK);
            #1 MOSI = 1'b1;
            @(negedge SCLK);
        end
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if (slaveDataReceived !== 8'h00) $display("FAIL mid_reset_rx: got %h want 00", slaveDataReceived);
        else n_pass++;
        n_checks++;
        if (MISO !== EXP_RESET_MISO) $display("FAIL mid_reset_miso: got %b want %b", MISO, EXP_RESET_MISO);
        else n_pass++;
        CS = 1'b1;
        #1 reset = 1'b1;
        run_frame(8'h5A, 16'h003C, 8, -1, 8'h00, got);
        n_checks++;
        if (slaveDataReceived !== 8'h3C) $display("FAIL post_mid_reset_rx: got %h want 3C", slaveDataReceived);
        else n_pass++;
        n_checks++;
        if (got[7:0] !== 8'h5A) $display("FAIL post_mid_reset_tx: got %h want 5A", got[7:0]);
        else n_pass++;
    endtask

    // Nine clocks in one frame: the ninth rise wraps MISO back to bit 0, the ninth fall publishes nothing.
    task automatic test_wrap();
        logic [15:0] got;
        logic [8:0]  got9;
        run_frame(8'h81, 16'h01A5, 9, -1, 8'h00, got);
        got9 = got[8:0];
        n_checks++;
        if (got9 !== 9'h181) $display("FAIL wrap_tx: got %h want 181", got9);
        else n_pass++;
        n_checks++;
        if (slaveDataReceived !== 8'hA5) $display("FAIL wrap_rx: got %h want A5", slaveDataReceived);
        else n_pass++;
    endtask

    initial begin
        n_checks = 0;
        n_pass = 0;
        MOSI = 1'b0;
        CS = 1'b1;
        slaveDataToSend = 8'h00;
        test_reset();
        test_full_duplex();
        test_back_to_back();
        test_miso_idle();
        test_abort();
        test_midframe_tx_change();
        test_midframe_reset();
        test_wrap();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
